neuron_mac_seq: RTL

Sequencer for one shared combinational 8x8 sign-magnitude multiplier inside a neuron. On start it fetches len input/weight pairs from synchronous operand memory, one pair per cycle. It drives each pair into the external multiplier, registers the products and accumulates them in two's complement. It then adds a bias, optionally applies ReLU, and emits a full-precision sum plus a saturated 8-bit sign-magnitude activation for the next layer.

---
 rtl/neuron_mac_seq_if.sv | 23 ++
 rtl/neuron_mac_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq_if.sv
// Operand-memory read port and shared-multiplier port seen by one neuron sequencer.
// master = sequencer, slave = memory/multiplier side.
interface neuron_mac_seq_if #(
    parameter int IDX_W = 4
);
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_x;
    logic [7:0]       rd_w;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [15:0]      mul_p;

    modport master (
        output rd_en, rd_idx, mul_a, mul_b,
        input  rd_x, rd_w, mul_p
    );

    modport slave (
        input  rd_en, rd_idx, mul_a, mul_b,
        output rd_x, rd_w, mul_p
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// Neuron MAC sequencer: streams len operand pairs through a shared sign-magnitude multiplier,
// accumulates in two's complement, adds bias, optional ReLU, emits sum and saturated activation.
module neuron_mac_seq #(
    parameter int N_MAX = 16,
    parameter int IDX_W = 4,
    parameter int LEN_W = 5,
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic signed [15:0]      bias,
    input  logic                    relu_en,
    neuron_mac_seq_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        acc_out,
    output logic [7:0]              y_out
);
    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFinish} state_t;

    state_t                    state_q;
    logic [LEN_W-1:0]          len_q;
    logic signed [15:0]        bias_q;
    logic                      relu_q;
    logic                      rd_en_q;
    logic [IDX_W-1:0]          rd_idx_q;
    logic                      rdv_q, mulv_q, prodv_q;
    logic [7:0]                mul_a_q, mul_b_q;
    logic [ACC_W-1:0]          prod_q, acc_q, acc_out_q;
    logic [7:0]                y_q;
    logic                      done_q;

    logic [LEN_W-1:0]          len_eff;
    logic [LEN_W-1:0]          idx_ext;
    logic [14:0]               mag;
    logic [ACC_W-1:0]          prod_d;
    logic signed [ACC_W-1:0]   sum, relu_v, sh;
    logic [ACC_W-1:0]          sh_abs;
    logic [6:0]                y_mag;
    logic [7:0]                y_d;

    assign bus.rd_en  = rd_en_q;
    assign bus.rd_idx = rd_idx_q;
    assign bus.mul_a  = mul_a_q;
    assign bus.mul_b  = mul_b_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign acc_out    = acc_out_q;
    assign y_out      = y_q;

    // Out-of-range requests are clamped so the index counter can never run past memory.
    assign len_eff = (len > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : len;
    assign idx_ext = LEN_W'(rd_idx_q);
    assign mag     = bus.mul_p[14:0];

    always_comb begin
        prod_d = '0;
        if (mag != 15'd0) begin
            prod_d = bus.mul_p[15] ? -ACC_W'(mag) : ACC_W'(mag);
        end
    end

    always_comb begin
        sum    = acc_q + {{(ACC_W-16){bias_q[15]}}, bias_q};
        relu_v = (relu_q && sum[ACC_W-1]) ? '0 : sum;
        sh     = relu_v >>> SHIFT;
        sh_abs = sh[ACC_W-1] ? -sh : sh;
        y_mag  = (sh_abs > ACC_W'(127)) ? 7'd127 : sh_abs[6:0];
        // A negative shifted value has magnitude >= 1, so zero always encodes as 8'h00.
        y_d    = {sh[ACC_W-1], y_mag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_idx_q  <= '0;
            rdv_q     <= 1'b0;
            mulv_q    <= 1'b0;
            prodv_q   <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
            acc_out_q <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rdv_q   <= rd_en_q;
            mulv_q  <= rdv_q;
            prodv_q <= mulv_q;
            if (rdv_q) begin
                mul_a_q <= bus.rd_x;
                mul_b_q <= bus.rd_w;
            end
            if (mulv_q) begin
                prod_q <= prod_d;
            end
            if (prodv_q) begin
                acc_q <= acc_q + prod_q;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q  <= len_eff;
                        bias_q <= bias;
                        relu_q <= relu_en;
                        acc_q  <= '0;
                        if (len_eff != '0) begin
                            state_q  <= StFetch;
                            rd_en_q  <= 1'b1;
                            rd_idx_q <= '0;
                        end else begin
                            state_q <= StFinish;
                        end
                    end
                end
                StFetch: begin
                    if (idx_ext + LEN_W'(1) == len_q) begin
                        rd_en_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rd_idx_q <= rd_idx_q + IDX_W'(1);
                    end
                end
                StDrain: begin
                    // Only the final product is left in flight; it lands in acc_q at this edge.
                    if (prodv_q && !mulv_q && !rdv_q) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    acc_out_q <= sum;
                    y_q       <= y_d;
                    done_q    <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
